// File: rtl/opf_pkg.sv
// Shared widths, operand-state and instruction types for the operand-fetch stage.
// The structs are sized from the package defaults below.
package opf_pkg;

    localparam int unsigned OpfDataW = 16;
    localparam int unsigned OpfSelW  = 3;
    localparam int unsigned OpfCtrlW = 8;

    typedef struct packed {
        logic [OpfDataW-1:0] data;
        logic                fresh;
    } opnd_state_t;

    typedef struct packed {
        logic [OpfSelW-1:0]  src_a;
        logic [OpfSelW-1:0]  src_b;
        logic                use_a;
        logic                use_b;
        logic [OpfSelW-1:0]  dst;
        logic                wr;
        logic [OpfCtrlW-1:0] ctrl;
    } in_instr_t;

    typedef struct packed {
        logic [OpfDataW-1:0] a;
        logic [OpfDataW-1:0] b;
        logic [OpfSelW-1:0]  dst;
        logic                wr;
        logic [OpfCtrlW-1:0] ctrl;
    } out_instr_t;

    function automatic logic sel_hit(input logic en, input logic [OpfSelW-1:0] sel_a,
                                     input logic [OpfSelW-1:0] sel_b);
        return en && (sel_a == sel_b);
    endfunction

    // Operand holding register update. A writeback landing on the accept edge
    // means the register file sample is stale, so wb data is captured instead.
    function automatic opnd_state_t opnd_next(input opnd_state_t cur,
                                              input logic accept,
                                              input logic held,
                                              input logic acc_hit,
                                              input logic wb_hit,
                                              input logic [OpfDataW-1:0] port,
                                              input logic [OpfDataW-1:0] wb_data);
        opnd_state_t nxt;
        nxt = cur;
        if (accept) begin
            if (acc_hit) begin
                nxt.data  = wb_data;
                nxt.fresh = 1'b0;
            end else begin
                nxt.fresh = 1'b1;
            end
        end else if (held) begin
            if (wb_hit) begin
                nxt.data  = wb_data;
                nxt.fresh = 1'b0;
            end else if (cur.fresh) begin
                nxt.data  = port;
                nxt.fresh = 1'b0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/opf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue to execute,
// cleared on writeback, set wins on a same-edge collision. Answers RAW/WAW queries.
module opf_scoreboard #(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [SEL_W-1:0] set_sel_i,
    input  logic             clr_en_i,
    input  logic [SEL_W-1:0] clr_sel_i,
    input  logic [SEL_W-1:0] src_a_i,
    input  logic             use_a_i,
    input  logic             byp_a_i,
    input  logic [SEL_W-1:0] src_b_i,
    input  logic             use_b_i,
    input  logic             byp_b_i,
    input  logic [SEL_W-1:0] dst_i,
    input  logic             wr_i,
    output logic             raw_o,
    output logic             waw_o
);

    localparam int unsigned NumRegs = 2 ** SEL_W;

    logic [NumRegs-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_sel_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A bypassed source is satisfied this cycle even though its bit is still set.
    assign raw_o = (use_a_i && pending_q[src_a_i] && !byp_a_i) ||
                   (use_b_i && pending_q[src_b_i] && !byp_b_i);
    assign waw_o = wr_i && pending_q[dst_i];

endmodule

// File: rtl/opnd_fetch.sv
// Operand-fetch stage: one-entry holding stage with writeback snooping and hazard stall.
// Define OPF_BYPASS_EN to forward writeback data combinationally onto out_a_o/out_b_o.
module opnd_fetch
    import opf_pkg::*;
#(
    parameter int unsigned DATA_W = OpfDataW,
    parameter int unsigned SEL_W  = OpfSelW,
    parameter int unsigned CTRL_W = OpfCtrlW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [SEL_W-1:0]  in_src_a_i,
    input  logic [SEL_W-1:0]  in_src_b_i,
    input  logic              in_use_a_i,
    input  logic              in_use_b_i,
    input  logic [SEL_W-1:0]  in_dst_i,
    input  logic              in_wr_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic [SEL_W-1:0]  rd_a_sel_o,
    output logic [SEL_W-1:0]  rd_b_sel_o,
    input  logic [DATA_W-1:0] rd_a_port_i,
    input  logic [DATA_W-1:0] rd_b_port_i,
    input  logic              wb_wr_en_i,
    input  logic [SEL_W-1:0]  wb_wr_sel_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [SEL_W-1:0]  out_dst_o,
    output logic              out_wr_o,
    output logic [CTRL_W-1:0] out_ctrl_o
);

    in_instr_t   s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    opnd_state_t opa_q, opa_d, opb_q, opb_d;

    logic              accept, out_fire, out_valid, in_ready;
    logic              raw, waw, hazard;
    logic              wb_hit_a, wb_hit_b, acc_hit_a, acc_hit_b;
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] opa_val, opb_val;
    out_instr_t        out_w;

    // The register file samples the selects every cycle; only the accept-edge sample is used.
    assign rd_a_sel_o = in_src_a_i;
    assign rd_b_sel_o = in_src_b_i;

    assign wb_hit_a  = sel_hit(wb_wr_en_i, wb_wr_sel_i, s1_q.src_a);
    assign wb_hit_b  = sel_hit(wb_wr_en_i, wb_wr_sel_i, s1_q.src_b);
    assign acc_hit_a = sel_hit(wb_wr_en_i, wb_wr_sel_i, in_src_a_i);
    assign acc_hit_b = sel_hit(wb_wr_en_i, wb_wr_sel_i, in_src_b_i);

`ifdef OPF_BYPASS_EN
    assign byp_a = s1_valid_q && wb_hit_a;
    assign byp_b = s1_valid_q && wb_hit_b;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    always_comb begin
        opa_val = opa_q.fresh ? rd_a_port_i : opa_q.data;
        opb_val = opb_q.fresh ? rd_b_port_i : opb_q.data;
        if (byp_a) begin
            opa_val = wb_data_i;
        end
        if (byp_b) begin
            opb_val = wb_data_i;
        end
    end

    opf_scoreboard #(
        .SEL_W (SEL_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (out_fire && s1_q.wr),
        .set_sel_i (s1_q.dst),
        .clr_en_i  (wb_wr_en_i),
        .clr_sel_i (wb_wr_sel_i),
        .src_a_i   (s1_q.src_a),
        .use_a_i   (s1_q.use_a),
        .byp_a_i   (byp_a),
        .src_b_i   (s1_q.src_b),
        .use_b_i   (s1_q.use_b),
        .byp_b_i   (byp_b),
        .dst_i     (s1_q.dst),
        .wr_i      (s1_q.wr),
        .raw_o     (raw),
        .waw_o     (waw)
    );

    assign hazard    = raw || waw;
    assign out_valid = s1_valid_q && !hazard;
    assign out_fire  = out_valid && out_ready_i;
    assign in_ready  = !s1_valid_q || out_fire;
    assign accept    = in_valid_i && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.src_a = in_src_a_i;
            s1_d.src_b = in_src_b_i;
            s1_d.use_a = in_use_a_i;
            s1_d.use_b = in_use_b_i;
            s1_d.dst   = in_dst_i;
            s1_d.wr    = in_wr_i;
            s1_d.ctrl  = in_ctrl_i;
        end else if (out_fire) begin
            s1_valid_d = 1'b0;
        end
        opa_d = opnd_next(opa_q, accept, s1_valid_q, acc_hit_a, wb_hit_a, rd_a_port_i, wb_data_i);
        opb_d = opnd_next(opb_q, accept, s1_valid_q, acc_hit_b, wb_hit_b, rd_b_port_i, wb_data_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
        end
    end

    always_comb begin
        out_w.a    = opa_val;
        out_w.b    = opb_val;
        out_w.dst  = s1_q.dst;
        out_w.wr   = s1_q.wr;
        out_w.ctrl = s1_q.ctrl;
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign out_a_o     = out_w.a;
    assign out_b_o     = out_w.b;
    assign out_dst_o   = out_w.dst;
    assign out_wr_o    = out_w.wr;
    assign out_ctrl_o  = out_w.ctrl;

endmodule
